// File: rtl/i3c_bus_frontend.sv
// I3C bus-condition front end: pin synchronizer, glitch filter, START/Sr/STOP detection, bit/byte assembly.
// Optional build macro I3C_FE_GLITCH_CNT_EN adds a saturating glitch_cnt output.
module i3c_bus_frontend #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3,
  parameter int unsigned IDLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_raw,
  input  logic       sda_raw,
  input  logic       enable,
  output logic       scl_f,
  output logic       sda_f,
  output logic       start_pulse,
  output logic       rstart_pulse,
  output logic       stop_pulse,
  output logic       bit_valid,
  output logic       bit_data,
  output logic [3:0] bit_idx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       bus_busy,
  output logic       bus_free
`ifdef I3C_FE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int unsigned FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    FREE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  // Line index 0 is SCL, 1 is SDA.
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                  sync_out;
  logic [1:0][FW-1:0]          fcnt_q;
  logic [1:0]                  filt_q;

  assign raw = {sda_raw, scl_raw};

  always_comb begin
    for (int i = 0; i < 2; i++) sync_out[i] = sync_q[i][SYNC_STAGES-1];
  end

  // Synchronizer chain plus per-line stability filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      fcnt_q <= '0;
      filt_q <= '1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (sync_out[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILT_CYCLES - 1)) begin
          filt_q[i] <= ~filt_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FW'(1);
        end
      end
    end
  end

  assign scl_f = filt_q[0];
  assign sda_f = filt_q[1];

`ifdef I3C_FE_GLITCH_CNT_EN
  logic [1:0] glitch;
  logic [8:0] glitch_sum;

  // A pending filter count that collapses back to zero is a rejected glitch.
  always_comb begin
    for (int i = 0; i < 2; i++) glitch[i] = (sync_out[i] == filt_q[i]) && (fcnt_q[i] != '0);
  end

  assign glitch_sum = 9'(glitch_cnt) + 9'(glitch[0]) + 9'(glitch[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) glitch_cnt <= '0;
    else     glitch_cnt <= (glitch_sum > 9'd255) ? 8'hFF : glitch_sum[7:0];
  end
`endif

  logic                   scl_d, sda_d;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   primed;

  // Idle counting waits until the reset contents of the synchronizers have been flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d   <= 1'b1;
      sda_d   <= 1'b1;
      prime_q <= '0;
    end else begin
      scl_d   <= scl_f;
      sda_d   <= sda_f;
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign primed = prime_q[SYNC_STAGES-1];

  logic start_cond, stop_cond, scl_rise, line_idle;

  assign start_cond = scl_d & scl_f & sda_d & ~sda_f;
  assign stop_cond  = scl_d & scl_f & ~sda_d & sda_f;
  assign scl_rise   = ~scl_d & scl_f;
  assign line_idle  = scl_f & sda_f & primed;

  state_t        state_q, state_nxt;
  logic [IW-1:0] idle_q, idle_nxt;
  logic [3:0]    idx_q, idx_nxt;
  logic [6:0]    shift_q, shift_nxt;
  logic [7:0]    sample_byte;
  logic          start_nxt, rstart_nxt, stop_nxt, bv_nxt, bdata_nxt, byv_nxt;
  logic [3:0]    bidx_nxt;
  logic [7:0]    byte_nxt;

  assign sample_byte = {shift_q, sda_f};

  always_comb begin
    state_nxt  = state_q;
    idle_nxt   = idle_q;
    idx_nxt    = idx_q;
    shift_nxt  = shift_q;
    start_nxt  = 1'b0;
    rstart_nxt = 1'b0;
    stop_nxt   = 1'b0;
    bv_nxt     = 1'b0;
    bdata_nxt  = bit_data;
    bidx_nxt   = bit_idx;
    byv_nxt    = 1'b0;
    byte_nxt   = byte_data;
    if (!enable) begin
      state_nxt = WAIT_IDLE;
      idle_nxt  = '0;
      idx_nxt   = '0;
      bidx_nxt  = '0;
    end else begin
      case (state_q)
        WAIT_IDLE, FREE: begin
          if (start_cond) begin
            start_nxt = 1'b1;
            state_nxt = ACTIVE;
            idle_nxt  = '0;
            idx_nxt   = '0;
            bidx_nxt  = '0;
          end else if (state_q == WAIT_IDLE) begin
            if (idle_q == IW'(IDLE_CYCLES)) state_nxt = FREE;
            else if (line_idle)             idle_nxt  = idle_q + IW'(1);
            else                            idle_nxt  = '0;
          end
        end
        ACTIVE: begin
          if (start_cond) begin
            rstart_nxt = 1'b1;
            idx_nxt    = '0;
            bidx_nxt   = '0;
            shift_nxt  = '0;
          end else if (stop_cond) begin
            stop_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
            idle_nxt  = '0;
            idx_nxt   = '0;
            bidx_nxt  = '0;
          end else if (scl_rise) begin
            bv_nxt    = 1'b1;
            bdata_nxt = sda_f;
            bidx_nxt  = idx_q;
            shift_nxt = sample_byte[6:0];
            idx_nxt   = (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
            if (idx_q == 4'd7) begin
              byv_nxt  = 1'b1;
              byte_nxt = sample_byte;
            end
          end
        end
        default: state_nxt = WAIT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_IDLE;
      idle_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      start_pulse  <= 1'b0;
      rstart_pulse <= 1'b0;
      stop_pulse   <= 1'b0;
      bit_valid    <= 1'b0;
      bit_data     <= 1'b0;
      bit_idx      <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
    end else begin
      state_q      <= state_nxt;
      idle_q       <= idle_nxt;
      idx_q        <= idx_nxt;
      shift_q      <= shift_nxt;
      start_pulse  <= start_nxt;
      rstart_pulse <= rstart_nxt;
      stop_pulse   <= stop_nxt;
      bit_valid    <= bv_nxt;
      bit_data     <= bdata_nxt;
      bit_idx      <= bidx_nxt;
      byte_valid   <= byv_nxt;
      byte_data    <= byte_nxt;
    end
  end

  assign bus_busy = (state_q == ACTIVE);
  assign bus_free = (state_q == FREE);

endmodule

// File: tb/tb_i3c_bus_frontend.sv
// Directed self-checking bench for i3c_bus_frontend at default parameters.
// Builds with or without I3C_FE_GLITCH_CNT_EN.
module tb_i3c_bus_frontend;

  localparam int unsigned H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_raw = 1'b1;
  logic       sda_raw = 1'b1;
  logic       enable = 1'b1;
  logic       scl_f, sda_f, start_pulse, rstart_pulse, stop_pulse;
  logic       bit_valid, bit_data, byte_valid, bus_busy, bus_free;
  logic [3:0] bit_idx;
  logic [7:0] byte_data;
`ifdef I3C_FE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  i3c_bus_frontend dut (
    .clk          (clk),
    .rst          (rst),
    .scl_raw      (scl_raw),
    .sda_raw      (sda_raw),
    .enable       (enable),
    .scl_f        (scl_f),
    .sda_f        (sda_f),
    .start_pulse  (start_pulse),
    .rstart_pulse (rstart_pulse),
    .stop_pulse   (stop_pulse),
    .bit_valid    (bit_valid),
    .bit_data     (bit_data),
    .bit_idx      (bit_idx),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .bus_busy     (bus_busy),
    .bus_free     (bus_free)
`ifdef I3C_FE_GLITCH_CNT_EN
    ,
    .glitch_cnt   (glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the inactive edge.
  int         n_start = 0, n_rstart = 0, n_stop = 0, n_bv = 0, n_byv = 0;
  logic [7:0] last_byte = 8'h00;
  logic       busy_prev = 1'b0, busy_at_stop = 1'b1, busy_before_stop = 1'b0;
  logic [3:0] idx_log [0:255];
  logic       bit_log [0:255];

  always @(negedge clk) begin
    if (start_pulse)  n_start  <= n_start + 1;
    if (rstart_pulse) n_rstart <= n_rstart + 1;
    if (stop_pulse) begin
      n_stop           <= n_stop + 1;
      busy_at_stop     <= bus_busy;
      busy_before_stop <= busy_prev;
    end
    if (bit_valid) begin
      idx_log[n_bv[7:0]] <= bit_idx;
      bit_log[n_bv[7:0]] <= bit_data;
      n_bv               <= n_bv + 1;
    end
    if (byte_valid) begin
      n_byv     <= n_byv + 1;
      last_byte <= byte_data;
    end
    busy_prev <= bus_busy;
  end

  task automatic set_bus(input logic c, input logic d);
    scl_raw = c;
    sda_raw = d;
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    set_bus(1'b0, sda_raw);
    set_bus(1'b0, b);
    set_bus(1'b1, b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_stop();
    if (!(scl_raw && !sda_raw)) begin
      set_bus(1'b0, sda_raw);
      set_bus(1'b0, 1'b0);
      set_bus(1'b1, 1'b0);
    end
    set_bus(1'b1, 1'b1);
  endtask

  task automatic do_sr();
    set_bus(1'b0, sda_raw);
    set_bus(1'b0, 1'b1);
    set_bus(1'b1, 1'b1);
    set_bus(1'b1, 1'b0);
  endtask

  int b_start, b_rstart, b_stop, b_bv, b_byv, lat;
  logic [8:0] word;
  logic       sda_min;

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_f",    32'(scl_f), 1);
    check("rst_sda_f",    32'(sda_f), 1);
    check("rst_pulses",   32'({start_pulse, rstart_pulse, stop_pulse, bit_valid, byte_valid}), 0);
    check("rst_bit_idx",  32'(bit_idx), 0);
    check("rst_byte",     32'(byte_data), 0);
    check("rst_status",   32'({bus_busy, bus_free}), 0);

    // Power-up idle: bus_free after SYNC_STAGES+IDLE_CYCLES+1 cycles.
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (bus_free) begin
        lat = i;
        break;
      end
    end
    check("free_latency", 32'(lat), 67);
    check("idle_no_pulse", 32'(n_start + n_rstart + n_stop + n_bv + n_byv), 0);

    // Address byte 0xA4 with ACK=0, START latency measured from raw edge.
    b_start = n_start; b_stop = n_stop; b_bv = n_bv; b_byv = n_byv;
    sda_raw = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (start_pulse) begin
        lat = i;
        break;
      end
    end
    check("start_latency", 32'(lat), 6);
    repeat (H) @(posedge clk);
    #1;
    check("busy_after_start", 32'(bus_busy), 1);
    send_byte(8'hA4);
    send_bit(1'b0);
    check("busy_before_stop", 32'(bus_busy), 1);
    do_stop();
    check("addr_start_cnt", 32'(n_start - b_start), 1);
    check("addr_bv_cnt",    32'(n_bv - b_bv), 9);
    for (int k = 0; k < 9; k++) check("addr_bit_idx", 32'(idx_log[b_bv + k]), 32'(k));
    word = '0;
    for (int k = 0; k < 9; k++) word = {word[7:0], bit_log[b_bv + k]};
    check("addr_bits",      32'(word), 32'h148);
    check("addr_byv_cnt",   32'(n_byv - b_byv), 1);
    check("addr_byte",      32'(last_byte), 32'hA4);
    check("addr_stop_cnt",  32'(n_stop - b_stop), 1);
    check("stop_busy_edge", 32'({busy_before_stop, busy_at_stop}), 32'b10);
    check("after_stop_free", 32'({bus_busy, bus_free}), 0);

    // Repeated START after 4 bits, then 0x3C.
    b_start = n_start; b_rstart = n_rstart; b_bv = n_bv; b_byv = n_byv;
    set_bus(1'b1, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    do_sr();
    send_byte(8'h3C);
    send_bit(1'b0);
    do_stop();
    check("sr_start_cnt",  32'(n_start - b_start), 1);
    check("sr_rstart_cnt", 32'(n_rstart - b_rstart), 1);
    check("sr_bv_cnt",     32'(n_bv - b_bv), 14);
    check("sr_setup_idx",  32'(idx_log[b_bv + 4]), 4);
    check("sr_first_idx",  32'(idx_log[b_bv + 5]), 0);
    check("sr_byv_cnt",    32'(n_byv - b_byv), 1);
    check("sr_byte",       32'(last_byte), 32'h3C);

    // 2-cycle SDA glitch while SCL high is rejected.
    b_start = n_start;
    sda_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sda_raw = 1'b1;
    sda_min = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      sda_min = sda_min & sda_f;
    end
    check("glitch_sda_f",  32'(sda_min), 1);
    check("glitch_no_start", 32'(n_start - b_start), 0);
`ifdef I3C_FE_GLITCH_CNT_EN
    check("glitch_cnt", 32'(glitch_cnt), 1);
`endif

    // 3-cycle SDA pulse is just wide enough: START then STOP.
    b_start = n_start; b_stop = n_stop;
    sda_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sda_raw = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("min_width_start", 32'(n_start - b_start), 1);
    check("min_width_stop",  32'(n_stop - b_stop), 1);

    // Simultaneous SCL/SDA edges are data, not conditions.
    set_bus(1'b1, 1'b0);
    set_bus(1'b0, 1'b0);
    set_bus(1'b0, 1'b1);
    b_rstart = n_rstart; b_stop = n_stop; b_bv = n_bv;
    set_bus(1'b1, 1'b0);
    check("simul_no_rstart", 32'(n_rstart - b_rstart), 0);
    check("simul_bv_cnt",    32'(n_bv - b_bv), 1);
    check("simul_bit0",      32'(bit_log[b_bv]), 0);
    set_bus(1'b0, 1'b0);
    set_bus(1'b1, 1'b1);
    check("simul_no_stop",   32'(n_stop - b_stop), 0);
    check("simul_bit1",      32'(bit_log[b_bv + 1]), 1);
    check("simul_busy",      32'(bus_busy), 1);
    do_stop();

    // Reset asserted at bit_idx=5.
    b_stop = n_stop;
    set_bus(1'b1, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("pre_rst_idx",  32'(bit_idx), 5);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus_busy), 0);
    check("mid_rst_idx",  32'(bit_idx), 0);
    check("mid_rst_byte", 32'(byte_data), 0);
    check("mid_rst_lines", 32'({scl_f, sda_f}), 32'b11);
    check("mid_rst_bit",  32'(bit_data), 0);
    scl_raw = 1'b1;
    sda_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_no_stop", 32'(n_stop - b_stop), 0);
    check("mid_rst_not_free", 32'(bus_free), 0);

    // Enable dropped mid-byte.
    set_bus(1'b1, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("dis_idx",  32'(bit_idx), 0);
    check("dis_busy", 32'(bus_busy), 0);
    b_start = n_start; b_rstart = n_rstart; b_stop = n_stop; b_bv = n_bv; b_byv = n_byv;
    send_bit(1'b1);
    send_bit(1'b0);
    do_stop();
    check("dis_no_pulses", 32'((n_start - b_start) + (n_rstart - b_rstart) + (n_stop - b_stop)
                               + (n_bv - b_bv) + (n_byv - b_byv)), 0);
    repeat (80) @(posedge clk);
    #1;
    check("dis_not_free", 32'(bus_free), 0);
    enable = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    check("reen_free", 32'(bus_free), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i3c_bus_frontend.md
# i3c_bus_frontend

Bus-condition front end for the I3C slave path. It synchronizes and glitch-filters the raw SCL/SDA pins and detects START, repeated START and STOP. It also samples data bits on SCL rising edges, assembles bytes, and tracks bus-free/busy status. Its single-cycle event pulses and assembled bytes feed the slave controller FSM directly, replacing ad-hoc sampling inside that FSM.

## Interface
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth per line, minimum 2.
- `FILT_CYCLES`, default 3: consecutive stable synchronized samples required before a filtered line changes, minimum 1.
- `IDLE_CYCLES`, default 64: cycles with SCL=SDA=1 needed to declare the bus free, minimum 2.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `scl_raw`  in  1: SCL pin input, asynchronous.
- `sda_raw`  in  1: SDA pin input, asynchronous.
- `enable`  in  1: front-end enable.
- `scl_f`  out  1: filtered SCL.
- `sda_f`  out  1: filtered SDA.
- `start_pulse`  out  1: START from free/idle bus, 1-cycle pulse.
- `rstart_pulse`  out  1: repeated START inside a frame, 1-cycle pulse.
- `stop_pulse`  out  1: STOP, 1-cycle pulse.
- `bit_valid`  out  1: data bit sampled, 1-cycle pulse.
- `bit_data`  out  1: sampled bit value.
- `bit_idx`  out  4: position within the 9-bit slot (0–7 data MSB first, 8 = ACK/T bit).
- `byte_valid`  out  1: 8 data bits assembled, 1-cycle pulse.
- `byte_data`  out  8: assembled byte, held until the next `byte_valid`.
- `bus_busy`  out  1: frame in progress.
- `bus_free`  out  1: bus idle for at least `IDLE_CYCLES` cycles.

## Operation
- **Synchronizer.** Each line is a `SYNC_STAGES`-deep flop chain.
- **Glitch filter.** Each line has a counter. It clears whenever the synchronized value equals the filtered value. Otherwise it increments; on reaching `FILT_CYCLES`, the filtered value toggles and the counter clears.
- **Event detection.** Uses the filtered values and their one-cycle-delayed copies (`scl_d`, `sda_d`).
  - START/Sr condition: `scl_d`=1, `scl_f`=1, `sda_d`=1, `sda_f`=0.
  - STOP condition: `scl_d`=1, `scl_f`=1, `sda_d`=0, `sda_f`=1.
  - An SDA edge in the same cycle as an SCL edge is a data change, not a condition.
- **FSM states:** WAIT_IDLE (reset state), FREE, ACTIVE.
  - WAIT_IDLE: the idle counter increments while `scl_f`=`sda_f`=1 and clears otherwise. When it reaches `IDLE_CYCLES`, go to FREE.
  - WAIT_IDLE or FREE, START condition: `start_pulse`, go to ACTIVE, `bit_idx`←0.
  - ACTIVE, START condition: `rstart_pulse`, stay in ACTIVE, `bit_idx`←0, partial byte discarded.
  - ACTIVE, STOP condition: `stop_pulse`, go to WAIT_IDLE, idle counter←0, `bit_idx`←0.
  - STOP outside ACTIVE: ignored, no pulse.
- **Bit sampling.** Active only in ACTIVE, on a `scl_f` rising edge with no concurrent condition.
  - `bit_valid`=1 and `bit_data`=`sda_f`; `bit_idx` shows the index of that bit.
  - `bit_idx` then advances, wrapping from 8 to 0.
  - At index 7, `byte_valid`=1 with `byte_data` equal to the 8 bits, first-sampled bit as MSB.
- **Status outputs.** `bus_busy` = (state==ACTIVE). `bus_free` = (state==FREE).
- **Enable.**
  - `enable`=0: the FSM is forced to WAIT_IDLE, all pulses are suppressed, the idle counter is held at 0, and `bit_idx`←0.
  - The synchronizers and filters keep running, so `scl_f`/`sda_f` stay valid.

## Timing
- **Reset values:** `scl_f`=1, `sda_f`=1, `scl_d`=`sda_d`=1, all pulses 0, `bit_data`=0, `bit_idx`=0, `byte_data`=0, `bus_busy`=0, `bus_free`=0, state WAIT_IDLE, all counters 0.
- **Latency:**
  - Raw pin edge to filtered output: `SYNC_STAGES`+`FILT_CYCLES` cycles.
  - Filtered edge to event pulse: +1 cycle, registered.
  - Default total: 6 cycles.
- **Pulse timing:** every pulse is exactly 1 cycle wide. `byte_valid` coincides with the `bit_valid` for index 7.
- **Minimum width:** a raw pulse shorter than `FILT_CYCLES` cycles after synchronization never reaches the filtered output.
- **Reset mid-frame:** outputs return to reset values immediately and asynchronously. No `stop_pulse` is generated. `bus_free` needs a fresh `IDLE_CYCLES` count.
- **Simultaneous events:** a START or STOP condition takes priority over bit sampling in the same cycle. Sr at `bit_idx`=8 resets the index to 0; no `byte_valid` is generated.

## Configuration
- **`I3C_FE_GLITCH_CNT_EN` defined:**
  - Adds an output port `glitch_cnt`  out  8.
  - The counter saturates at 255 and increments once per rejected glitch, on either line.
  - A glitch is a synchronized value that differed from the filtered value and then returned to it before the filter counter reached `FILT_CYCLES`.
  - `glitch_cnt` resets to 0 and is not cleared by `enable`.
- **Not defined:** the port and its logic are absent. Filtering behaviour is identical in both builds.

## Test plan
- **Power-up idle:** reset released, both lines held high → `bus_free` rises exactly `SYNC_STAGES`+`IDLE_CYCLES`+1 cycles after reset deassertion (67 cycles at defaults); no pulses.
- **Address byte:** START, then address byte 0xA4 with ACK = 0, then STOP. Required response:
  - `start_pulse` fires once.
  - Nine `bit_valid` pulses, with `bit_idx` 0–8.
  - `byte_valid` with `byte_data`=0xA4.
  - `stop_pulse` fires once.
  - `bus_busy` falls on the same cycle as `stop_pulse`.
- **Repeated START:** Sr after 4 data bits, then byte 0x3C → `rstart_pulse` fires once; the partial byte is discarded; the next `byte_valid` carries 0x3C; `start_pulse` does not fire again.
- **Glitch rejection:** 2-cycle SDA low pulse while SCL is high (`FILT_CYCLES`=3) → `sda_f` stays 1 and no START is detected; with `I3C_FE_GLITCH_CNT_EN`, `glitch_cnt`=1.
- **Simultaneous edge:** SCL and SDA change in the same cycle → no START/STOP pulse; the bit is sampled normally.
- **Mid-byte disruptions:**
  - `rst` asserted at `bit_idx`=5 → all outputs return to reset values.
  - Separately, `enable` dropped mid-byte → no further pulses, `bit_idx`=0, `bus_busy`=0.
